// File: rtl/bounce_emulator_pkg.sv
// Shared types and constants for the contact-bounce emulator and its LFSR.
package bounce_emulator_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GAP    = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   // Galois taps for x^16+x^14+x^13+x^11+1 with a right-shifting register
   localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// 16-bit Galois LFSR, reloadable from a seed; reused by other stimulus blocks.
module lfsr16
   import bounce_emulator_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= seed;
      end else if (advance) begin
         q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
      end
   end

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean level into a bouncy burst (random-length glitches, then a settled
// level) so the debouncer can be exercised without a mechanical switch.
module bounce_emulator
   import bounce_emulator_pkg::*;
#(
   parameter int unsigned BOUNCES      = 3,
   parameter int unsigned MIN_GAP      = 2,
   parameter int unsigned GAP_BITS     = 4,
   parameter int unsigned SETTLE_TICKS = 8,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic clean_in,
   input  logic enable,
   output logic bouncy_out,
   output logic busy
);

   localparam int GAP_W = $clog2(MIN_GAP + 2**GAP_BITS) + 1;
   localparam int TOG_W = $clog2(2*BOUNCES + 1) + 1;
   localparam int SET_W = $clog2(SETTLE_TICKS + 1) + 1;

   localparam logic [TOG_W-1:0] TOGGLES_INIT = TOG_W'(2*BOUNCES);
   localparam logic [SET_W-1:0] SETTLE_INIT  = SET_W'(SETTLE_TICKS);
   // Masking instead of slicing keeps GAP_BITS=0 legal (gap collapses to MIN_GAP)
   localparam logic [15:0]      GAP_MASK     = 16'((64'd1 << GAP_BITS) - 64'd1);

   state_t           state, state_n;
   logic             bouncy_n, busy_n;
   logic [GAP_W-1:0] gap_cnt, gap_n, gap_sample;
   logic [TOG_W-1:0] toggles_left, tog_n;
   logic [SET_W-1:0] settle_cnt, set_n;
   logic [15:0]      lfsr_q;

   lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .seed    (SEED),
      .advance (1'b1),
      .q       (lfsr_q)
   );

   assign gap_sample = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q & GAP_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         bouncy_out   <= 1'b0;
         busy         <= 1'b0;
         gap_cnt      <= '0;
         toggles_left <= '0;
         settle_cnt   <= '0;
      end else begin
         state        <= state_n;
         bouncy_out   <= bouncy_n;
         busy         <= busy_n;
         gap_cnt      <= gap_n;
         toggles_left <= tog_n;
         settle_cnt   <= set_n;
      end
   end

   // Bypass overrides everything; otherwise each toggle reloads either the next
   // random gap or, on the last toggle, the settle window.
   always_comb begin
      state_n  = state;
      bouncy_n = bouncy_out;
      busy_n   = busy;
      gap_n    = gap_cnt;
      tog_n    = toggles_left;
      set_n    = settle_cnt;
      if (!enable) begin
         state_n  = S_IDLE;
         bouncy_n = clean_in;
         busy_n   = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               busy_n = 1'b0;
               if (clean_in != bouncy_out) begin
                  bouncy_n = ~bouncy_out;
                  busy_n   = 1'b1;
                  tog_n    = TOGGLES_INIT;
                  if (TOGGLES_INIT == '0) begin
                     set_n   = SETTLE_INIT;
                     state_n = S_SETTLE;
                  end else begin
                     gap_n   = gap_sample;
                     state_n = S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  bouncy_n = ~bouncy_out;
                  tog_n    = toggles_left - TOG_W'(1);
                  if (toggles_left <= TOG_W'(1)) begin
                     set_n   = SETTLE_INIT;
                     state_n = S_SETTLE;
                  end else begin
                     gap_n = gap_sample;
                  end
               end else begin
                  gap_n = gap_cnt - GAP_W'(1);
               end
            end
            S_SETTLE: begin
               if (settle_cnt <= SET_W'(1)) begin
                  state_n = S_IDLE;
                  busy_n  = 1'b0;
               end else begin
                  set_n = settle_cnt - SET_W'(1);
               end
            end
            default: begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench: a deterministic instance checked cycle-by-cycle against a timeline
// scoreboard, plus a default instance driven with random transitions.
module tb_bounce_emulator;

   localparam int D_TOG    = 5;
   localparam int D_GAP    = 3;
   localparam int D_SETTLE = 4;
   localparam int DEB_TICKS = 20;

   typedef struct {
      int   cyc;
      logic bouncy;
      logic busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clean_in = 1'b0;
   logic enable = 1'b1;
   logic bouncy_out, busy;
   logic clean2 = 1'b0;
   logic bouncy2, busy2;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   logic tgtQ[$];

   int   lastT = 0;
   int   togCnt = 0;
   logic prevB2 = 1'b0;
   logic prevBusy2 = 1'b0;
   logic debLvl = 1'b0;
   int   debCnt = 0;
   int   debChanges = 0;

   bounce_emulator #(
      .BOUNCES      (2),
      .MIN_GAP      (3),
      .GAP_BITS     (0),
      .SETTLE_TICKS (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clean_in   (clean_in),
      .enable     (enable),
      .bouncy_out (bouncy_out),
      .busy       (busy)
   );

   bounce_emulator dut2 (
      .clk        (clk),
      .rst        (rst),
      .clean_in   (clean2),
      .enable     (1'b1),
      .bouncy_out (bouncy2),
      .busy       (busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Expected waveform of one burst on the deterministic instance starting at edge s
   task automatic pushBurst(input int s, input logic lvl0, input int fromE, input int toE);
      for (int e = fromE; e <= toE; e++) begin
         int   n;
         exp_t x;
         n = (e < s) ? 0 : ((e - s) / D_GAP + 1);
         if (n > D_TOG) n = D_TOG;
         x.cyc    = e;
         x.bouncy = lvl0 ^ n[0];
         x.busy   = (e >= s) && (e < s + (D_TOG - 1) * D_GAP + D_SETTLE);
         sbq.push_back(x);
      end
   endtask

   task automatic pushLevel(input int e, input logic b, input logic bz);
      exp_t x;
      x.cyc    = e;
      x.bouncy = b;
      x.busy   = bz;
      sbq.push_back(x);
   endtask

   // Drives inputs so that they are sampled at posedge edgeNum
   task automatic applyStimulus(input int edgeNum, input logic cleanVal, input logic enVal, input logic rstVal);
      while (cyc < edgeNum - 1) @(negedge clk);
      clean_in = cleanVal;
      enable   = enVal;
      rst      = rstVal;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst      = 1'b1;
      clean_in = 1'b0;
      enable   = 1'b1;
      @(negedge clk);
      checkOutput("rst_bouncy", bouncy_out, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_bouncy2", bouncy2, 0);
      rst = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) begin
         checkOutput("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
   endtask

   // Scoreboard for the deterministic instance: compare every entry due this cycle
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         if (e.cyc < cyc) begin
            checkOutput("sb_missed", e.cyc, cyc);
         end else begin
            checkOutput("bouncy", bouncy_out, e.bouncy);
            checkOutput("busy", busy, e.busy);
         end
      end
   end

   // Burst monitor and reference debouncer for the default instance
   always @(negedge clk) begin
      logic tgt;
      if (!rst) begin
         if (bouncy2 != prevB2) begin
            if (togCnt > 0) begin
               checkOutput("gap_range", 32'((cyc - lastT) >= 2 && (cyc - lastT) <= 17), 1);
            end
            togCnt++;
            lastT = cyc;
         end
         if (prevBusy2 && !busy2) begin
            checkOutput("burst_toggles", togCnt, 7);
            checkOutput("settle_len", cyc - lastT, 8);
            checkOutput("lfsr_nonzero", 32'(dut2.u_lfsr.q != 16'd0), 1);
            if (tgtQ.size() == 0) begin
               checkOutput("unexpected_burst", 1, 0);
            end else begin
               tgt = tgtQ.pop_front();
               checkOutput("final_level", bouncy2, tgt);
            end
            togCnt = 0;
         end
         if (bouncy2 == debLvl) begin
            debCnt = 0;
         end else begin
            debCnt++;
            if (debCnt >= DEB_TICKS) begin
               debLvl = bouncy2;
               debCnt = 0;
               debChanges++;
            end
         end
      end
      prevB2    = bouncy2;
      prevBusy2 = busy2;
   end

   initial begin
      int   base;
      int   lastDeb;
      logic v;

      doReset();

      $display("[TB] deterministic burst");
      base = cyc;
      pushBurst(base + 10, 1'b0, base + 9, base + 28);
      applyStimulus(base + 10, 1'b1, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] mid-burst reversal");
      doReset();
      base = cyc;
      pushBurst(base + 10, 1'b0, base + 9, base + 26);
      pushBurst(base + 27, 1'b1, base + 27, base + 45);
      applyStimulus(base + 10, 1'b1, 1'b1, 1'b0);
      applyStimulus(base + 15, 1'b0, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] reset mid-burst");
      doReset();
      base = cyc;
      pushBurst(base + 10, 1'b0, base + 9, base + 16);
      for (int e = base + 17; e <= base + 20; e++) pushLevel(e, 1'b0, 1'b0);
      pushBurst(base + 21, 1'b0, base + 21, base + 38);
      applyStimulus(base + 10, 1'b1, 1'b1, 1'b0);
      applyStimulus(base + 17, 1'b1, 1'b1, 1'b1);
      applyStimulus(base + 21, 1'b1, 1'b1, 1'b0);
      waitDrain();

      $display("[TB] enable drop and bypass");
      doReset();
      base = cyc;
      pushBurst(base + 10, 1'b0, base + 9, base + 13);
      applyStimulus(base + 10, 1'b1, 1'b1, 1'b0);
      applyStimulus(base + 14, 1'b1, 1'b0, 1'b0);
      pushLevel(base + 14, 1'b1, 1'b0);
      v = 1'b1;
      for (int e = base + 15; e <= base + 24; e++) begin
         v = ~v;
         applyStimulus(e, v, 1'b0, 1'b0);
         pushLevel(e, v, 1'b0);
      end
      waitDrain();

      $display("[TB] random transitions on default instance");
      doReset();
      lastDeb = debChanges;
      for (int i = 0; i < 200; i++) begin
         repeat (150 + $urandom_range(0, 50)) @(negedge clk);
         if (i > 0) begin
            checkOutput("deb_changes", debChanges - lastDeb, 1);
            checkOutput("deb_level", debLvl, clean2);
         end
         lastDeb = debChanges;
         clean2 = ~clean2;
         tgtQ.push_back(clean2);
      end
      repeat (200) @(negedge clk);
      checkOutput("deb_changes", debChanges - lastDeb, 1);
      checkOutput("deb_level", debLvl, clean2);
      checkOutput("tgt_drain", tgtQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bounce_emulator.md
# bounce_emulator

Synthesizable contact-bounce generator: converts a clean level into a realistic bouncy waveform (a burst of glitch toggles with pseudo-random spacing, then a settled level). It drives the button input of the team's `debouncer` on-board, or in simulation, so input conditioning can be exercised without mechanical switches. It sits in front of the input-conditioning chain of the rgb_sequencer example and is selectable per input via `enable`.

## Interface
- `BOUNCES`, 3: glitch pairs per transition. Total toggles per burst = 2*BOUNCES+1.
- `MIN_GAP`, 2: minimum cycles each burst level is held; must be ≥1.
- `GAP_BITS`, 4: random gap extension width. Gap = MIN_GAP + lfsr[GAP_BITS-1:0]. With 0, the gap is exactly MIN_GAP.
- `SETTLE_TICKS`, 8: cycles `busy` stays high after the final toggle.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `clean_in`  in  1  ideal level to emulate; synchronous to `clk`.
- `enable`  in  1  1 = emulate bounce; 0 = bypass.
- `bouncy_out`  out  1  emulated switch output.
- `busy`  out  1  burst or settle in progress.

## Operation
- States: S_IDLE, S_GAP, S_SETTLE.
- **Reset:**
  - `bouncy_out`=0, `busy`=0, state S_IDLE.
  - LFSR=SEED; toggle and gap counters cleared.
  - Reset mid-burst aborts immediately.
- **LFSR:**
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every non-reset cycle, regardless of state.
- **S_IDLE:**
  - `busy`=0.
  - If `enable` and `clean_in` != `bouncy_out`: toggle `bouncy_out`, load toggles_left=2*BOUNCES, load gap counter, go to S_GAP, set `busy`=1.
- **S_GAP:**
  - The gap counter decrements each cycle.
  - When the level has been held G cycles: toggle `bouncy_out` and decrement toggles_left.
  - If toggles_left was 1 at that toggle, load the settle counter and go to S_SETTLE; otherwise reload the gap counter.
- **Gap value:** G = MIN_GAP + lfsr[GAP_BITS-1:0], sampled on the toggle edge. Counter width is $clog2(MIN_GAP+2**GAP_BITS)+1 bits.
- **S_SETTLE:**
  - Holds `bouncy_out` for SETTLE_TICKS cycles, then goes to S_IDLE.
  - `clean_in` changes during this state are ignored until S_IDLE.
- **Burst parity:** the final level always equals the target captured at burst start, so an odd toggle count lands on the new level.
- **`clean_in` changes mid-burst:** the burst completes to its captured target. S_IDLE then re-compares and launches a new burst if the levels differ.
- **`enable`=0:**
  - Any state goes to S_IDLE; `busy`=0.
  - `bouncy_out` <= `clean_in` every cycle (one-cycle registered bypass).
  - Deassertion mid-burst aborts the burst.
- **BOUNCES=0:** single clean toggle, then settle.

## Timing
- Transition detected at posedge t (S_IDLE): `bouncy_out` and `busy` change after posedge t, so latency is 1 cycle from the `clean_in` change.
- Toggle k+1 occurs at posedge t_k + G_k.
- Final toggle at t_f. `busy` falls after posedge t_f+SETTLE_TICKS.
- Earliest new burst: posedge t_f+SETTLE_TICKS+1.
- All outputs registered; no combinational input-to-output path.
- Minimum burst duration = 2*BOUNCES*MIN_GAP cycles.

## Structure
- `bounce_emulator_pkg`: state enum (2-bit), `LFSR_MASK` constant 16'hB400.
- Sub-module `lfsr16`:
  - Ports: clk, rst, seed, advance, q[15:0].
  - Reusable by later test-stimulus blocks.
- Top module contains the FSM, gap, toggle and settle counters, and the bypass mux.

## Test plan
- **Deterministic burst.** BOUNCES=2, MIN_GAP=3, GAP_BITS=0, SETTLE_TICKS=4; `clean_in` 0->1 sampled at edge 10.
  - `bouncy_out` = 1/0/1/0/1 after edges 10/13/16/19/22.
  - `busy` high after edge 10, low after edge 26.
- **Bypass.** `enable`=0; toggle `clean_in` every cycle. `bouncy_out` equals `clean_in` delayed by 1 cycle; `busy` stays 0.
- **Mid-burst reversal.** Same parameters; `clean_in` 0->1 at edge 10, 1->0 at edge 15.
  - First burst ends at 1 after edge 22.
  - Second burst starts at edge 27 (`bouncy_out`=0) and ends at 0.
- **Reset and abort.**
  - Assert `rst` at edge 17 mid-burst: `bouncy_out`=0, `busy`=0 after edge 17; no toggles while `rst` is high.
  - Separately, drop `enable` mid-burst: `busy` falls next cycle.
- **Random gaps.** Defaults, 200 random `clean_in` transitions spaced ≥100 cycles.
  - Every gap is in [2,17].
  - Each burst has exactly 7 toggles.
  - LFSR never reaches 0.
- **Chain with debouncer.** BOUNCE_TICKS=20 > max gap 17. Debounced output changes exactly once per `clean_in` transition.
